// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control FSM: decodes instrCode, sequences FETCH/DECODE/EXECUTE/MEM/WB,
// drives the datapath selects and the RAM handshake, and counts retired instructions.
//
// state  | meaning
// FETCH  | instruction word settling from ROM, no datapath action
// DECODE | opcode dispatch; unknown opcode is skipped as a NOP here
// R_EXE  | register-register ALU op, write back, retire
// I_EXE  | register-immediate ALU op, write back, retire
// L_EXE  | load address computation
// L_MEM  | read strobe held until busReady or timeout
// L_WB   | load data write back, retire
// S_EXE  | store address computation
// S_MEM  | write strobe held until busReady or timeout, retire
// B_EXE  | branch compare, retire (taken select lives in the datapath)
// LU_EXE | LUI write back, retire
// AU_EXE | AUIPC write back, retire
// J_EXE  | JAL link write back, retire
// JL_EXE | JALR link write back, retire
module multicycle_control_unit #(
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instrCode,
    input  logic        busReady,
    output logic        PCEn,
    output logic        regFileWe,
    output logic        aluSrcMuxSel,
    output logic [3:0]  aluControl,
    output logic [2:0]  RFWDSrcMuxSel,
    output logic        branch,
    output logic        jal,
    output logic        jalr,
    output logic        busWe,
    output logic        busRe,
    output logic [2:0]  memFunct3,
    output logic        busErr,
    output logic        illegal,
    output logic [31:0] retiredCnt
);

    localparam int WCW = $clog2(MEM_WAIT_MAX + 1);

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_L     = 7'b0000011;
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;

    typedef enum logic [3:0] {
        FETCH, DECODE, R_EXE, I_EXE, L_EXE, L_MEM, L_WB,
        S_EXE, S_MEM, B_EXE, LU_EXE, AU_EXE, J_EXE, JL_EXE
    } state_t;

    state_t          state_q, state_d;
    logic [WCW-1:0]  wait_q, wait_d;
    logic [31:0]     cnt_q, cnt_d;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_b5;

    assign opcode    = instrCode[6:0];
    assign funct3    = instrCode[14:12];
    assign funct7_b5 = instrCode[30];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FETCH;
            wait_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        wait_d        = wait_q;
        PCEn          = 1'b0;
        regFileWe     = 1'b0;
        aluSrcMuxSel  = 1'b0;
        aluControl    = 4'b0000;
        RFWDSrcMuxSel = 3'd0;
        branch        = 1'b0;
        jal           = 1'b0;
        jalr          = 1'b0;
        busWe         = 1'b0;
        busRe         = 1'b0;
        memFunct3     = 3'd0;
        busErr        = 1'b0;
        illegal       = 1'b0;

        unique case (state_q)
            FETCH: state_d = DECODE;

            DECODE: begin
                unique case (opcode)
                    OP_R:     state_d = R_EXE;
                    OP_I:     state_d = I_EXE;
                    OP_L:     state_d = L_EXE;
                    OP_S:     state_d = S_EXE;
                    OP_B:     state_d = B_EXE;
                    OP_LUI:   state_d = LU_EXE;
                    OP_AUIPC: state_d = AU_EXE;
                    OP_JAL:   state_d = J_EXE;
                    OP_JALR:  state_d = JL_EXE;
                    default: begin
                        illegal = 1'b1;
                        PCEn    = 1'b1;
                        state_d = FETCH;
                    end
                endcase
            end

            R_EXE: begin
                aluControl = {funct7_b5, funct3};
                regFileWe  = 1'b1;
                PCEn       = 1'b1;
                state_d    = FETCH;
            end

            I_EXE: begin
                // only the shift-right immediates use funct7[5] (SRLI vs SRAI)
                aluSrcMuxSel = 1'b1;
                aluControl   = {(funct3 == 3'b101) ? funct7_b5 : 1'b0, funct3};
                regFileWe    = 1'b1;
                PCEn         = 1'b1;
                state_d      = FETCH;
            end

            B_EXE: begin
                aluControl = {1'b0, funct3};
                branch     = 1'b1;
                PCEn       = 1'b1;
                state_d    = FETCH;
            end

            LU_EXE: begin
                RFWDSrcMuxSel = 3'd2;
                regFileWe     = 1'b1;
                PCEn          = 1'b1;
                state_d       = FETCH;
            end

            AU_EXE: begin
                RFWDSrcMuxSel = 3'd3;
                regFileWe     = 1'b1;
                PCEn          = 1'b1;
                state_d       = FETCH;
            end

            J_EXE: begin
                jal           = 1'b1;
                RFWDSrcMuxSel = 3'd4;
                regFileWe     = 1'b1;
                PCEn          = 1'b1;
                state_d       = FETCH;
            end

            JL_EXE: begin
                jal           = 1'b1;
                jalr          = 1'b1;
                aluSrcMuxSel  = 1'b1;
                RFWDSrcMuxSel = 3'd4;
                regFileWe     = 1'b1;
                PCEn          = 1'b1;
                state_d       = FETCH;
            end

            L_EXE: begin
                aluSrcMuxSel = 1'b1;
                wait_d       = WCW'(MEM_WAIT_MAX);
                state_d      = L_MEM;
            end

            // Down-counter reaching zero means MEM_WAIT_MAX strobe cycles went unanswered
            L_MEM: begin
                if (wait_q == '0) begin
                    busErr  = 1'b1;
                    PCEn    = 1'b1;
                    state_d = FETCH;
                end else begin
                    busRe     = 1'b1;
                    memFunct3 = funct3;
                    wait_d    = wait_q - WCW'(1);
                    if (busReady) state_d = L_WB;
                end
            end

            L_WB: begin
                RFWDSrcMuxSel = 3'd1;
                memFunct3     = funct3;
                regFileWe     = 1'b1;
                PCEn          = 1'b1;
                state_d       = FETCH;
            end

            S_EXE: begin
                aluSrcMuxSel = 1'b1;
                wait_d       = WCW'(MEM_WAIT_MAX);
                state_d      = S_MEM;
            end

            S_MEM: begin
                if (wait_q == '0) begin
                    busErr  = 1'b1;
                    PCEn    = 1'b1;
                    state_d = FETCH;
                end else begin
                    busWe     = 1'b1;
                    memFunct3 = funct3;
                    wait_d    = wait_q - WCW'(1);
                    if (busReady) begin
                        PCEn    = 1'b1;
                        state_d = FETCH;
                    end
                end
            end

            default: state_d = FETCH;
        endcase

        cnt_d = cnt_q + {31'd0, PCEn};
    end

    assign retiredCnt = cnt_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Randomized bench for multicycle_control_unit: a per-instruction cycle schedule built from the
// opcode/latency rules is compared against every output on every cycle.
module tb_multicycle_control_unit;

    localparam int WMAX = 15;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instrCode;
    logic        busReady;
    logic        PCEn, regFileWe, aluSrcMuxSel, branch, jal, jalr;
    logic        busWe, busRe, busErr, illegal;
    logic [3:0]  aluControl;
    logic [2:0]  RFWDSrcMuxSel, memFunct3;
    logic [31:0] retiredCnt;

    typedef struct packed {
        logic       pcen;
        logic       we;
        logic       src;
        logic [3:0] alu;
        logic [2:0] rfwd;
        logic       br;
        logic       jal;
        logic       jalr;
        logic       bwe;
        logic       bre;
        logic [2:0] f3;
        logic       err;
        logic       ill;
    } vec_t;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] cnt_model;
    vec_t        exp_q[$];

    multicycle_control_unit #(.MEM_WAIT_MAX(WMAX)) dut (
        .clk(clk), .reset(reset), .instrCode(instrCode), .busReady(busReady),
        .PCEn(PCEn), .regFileWe(regFileWe), .aluSrcMuxSel(aluSrcMuxSel),
        .aluControl(aluControl), .RFWDSrcMuxSel(RFWDSrcMuxSel), .branch(branch),
        .jal(jal), .jalr(jalr), .busWe(busWe), .busRe(busRe), .memFunct3(memFunct3),
        .busErr(busErr), .illegal(illegal), .retiredCnt(retiredCnt)
    );

    always #5 clk = ~clk;

    function automatic vec_t observe();
        vec_t v;
        v = '{pcen: PCEn, we: regFileWe, src: aluSrcMuxSel, alu: aluControl,
              rfwd: RFWDSrcMuxSel, br: branch, jal: jal, jalr: jalr, bwe: busWe,
              bre: busRe, f3: memFunct3, err: busErr, ill: illegal};
        return v;
    endfunction

    function automatic bit is_legal(input logic [6:0] op);
        return op inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h67};
    endfunction

    // Expected per-cycle outputs of one instruction; w = wait cycles before busReady (>=WMAX: none in time)
    function automatic void build(input logic [31:0] ins, input int w);
        vec_t       z, v;
        logic [6:0] op;
        logic [2:0] f3;
        bit         ready;
        int         n;
        z  = '0;
        op = ins[6:0];
        f3 = ins[14:12];
        exp_q.delete();
        exp_q.push_back(z);
        if (!is_legal(op)) begin
            v = z; v.ill = 1'b1; v.pcen = 1'b1;
            exp_q.push_back(v);
            return;
        end
        exp_q.push_back(z);
        v = z;
        case (op)
            7'h33: begin v.alu = {ins[30], f3}; v.we = 1; v.pcen = 1; end
            7'h13: begin v.src = 1; v.alu = {(f3 == 3'd5) ? ins[30] : 1'b0, f3}; v.we = 1; v.pcen = 1; end
            7'h63: begin v.br = 1; v.alu = {1'b0, f3}; v.pcen = 1; end
            7'h37: begin v.rfwd = 3'd2; v.we = 1; v.pcen = 1; end
            7'h17: begin v.rfwd = 3'd3; v.we = 1; v.pcen = 1; end
            7'h6F: begin v.jal = 1; v.rfwd = 3'd4; v.we = 1; v.pcen = 1; end
            7'h67: begin v.jal = 1; v.jalr = 1; v.src = 1; v.rfwd = 3'd4; v.we = 1; v.pcen = 1; end
            default: v.src = 1;
        endcase
        exp_q.push_back(v);
        if (op != 7'h03 && op != 7'h23) return;
        ready = (w < WMAX);
        n = ready ? w + 1 : WMAX;
        for (int i = 0; i < n; i++) begin
            v = z; v.f3 = f3;
            if (op == 7'h03) v.bre = 1; else v.bwe = 1;
            if (ready && i == w && op == 7'h23) v.pcen = 1;
            exp_q.push_back(v);
        end
        if (!ready) begin
            v = z; v.err = 1; v.pcen = 1;
            exp_q.push_back(v);
        end else if (op == 7'h03) begin
            v = z; v.rfwd = 3'd1; v.we = 1; v.pcen = 1; v.f3 = f3;
            exp_q.push_back(v);
        end
    endfunction

    // Entered just after a rising edge with the DUT in FETCH; leaves the same way
    task automatic run_instr(input logic [31:0] ins, input int w, input string name);
        vec_t obs;
        build(ins, w);
        instrCode = ins;
        for (int k = 0; k < exp_q.size(); k++) begin
            if (k >= 3) busReady = ((k - 3) == w);
            else        busReady = 1'($urandom_range(0, 1));
            @(negedge clk);
            obs = observe();
            n_cmp++;
            if (obs !== exp_q[k]) begin
                n_bad++;
                $display("FAIL %s cyc%0d outputs got %h want %h", name, k, obs, exp_q[k]);
            end
            n_cmp++;
            if (retiredCnt !== cnt_model) begin
                n_bad++;
                $display("FAIL %s cyc%0d retiredCnt got %0d want %0d", name, k, retiredCnt, cnt_model);
            end
            if (exp_q[k].pcen) cnt_model++;
            @(posedge clk); #1;
        end
        busReady = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; instrCode = 32'h0040A283; busReady = 1'b1; cnt_model = '0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (observe() !== vec_t'('0)) begin
            n_bad++; $display("FAIL reset outputs got %h want 0", observe());
        end
        n_cmp++;
        if (retiredCnt !== 32'd0) begin
            n_bad++; $display("FAIL reset retiredCnt got %0d want 0", retiredCnt);
        end
        @(posedge clk); #1;
        reset = 1'b0; busReady = 1'b0;
    endtask

    task automatic test_directed();
        run_instr(32'h002081B3, 0, "add");
        run_instr(32'h402081B3, 0, "sub");
        run_instr(32'h4050D193, 0, "srai");
        run_instr(32'h0040A283, 2, "lw_wait2");
        run_instr(32'h0050A223, WMAX + 1, "sw_timeout");
        run_instr(32'h000100E7, 0, "jalr");
        run_instr(32'h00208463, 0, "beq");
        run_instr(32'h0000007F, 0, "illegal7f");
        run_instr(32'h123452B7, 0, "lui");
        run_instr(32'h00001297, 0, "auipc");
        run_instr(32'h008000EF, 0, "jal");
    endtask

    task automatic test_mem_boundary();
        run_instr(32'h0040A283, 0, "lw_ready0");
        run_instr(32'h0050A223, 0, "sw_ready0");
        run_instr(32'h0040A283, WMAX - 1, "lw_last_ok");
        run_instr(32'h0050A223, WMAX - 1, "sw_last_ok");
        run_instr(32'h0040A283, WMAX, "lw_late_ready");
        run_instr(32'h0050A223, WMAX, "sw_late_ready");
    endtask

    task automatic test_random();
        logic [6:0]  ops [9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h67};
        logic [31:0] ins;
        logic [6:0]  op;
        int          w;
        for (int i = 0; i < 60; i++) begin
            ins = $urandom;
            if ($urandom_range(0, 9) == 0) begin
                op = 7'($urandom);
                if (is_legal(op)) op = 7'h7F;
            end else begin
                op = ops[$urandom_range(0, 8)];
            end
            ins[6:0] = op;
            w = $urandom_range(0, WMAX + 1);
            run_instr(ins, w, "random");
        end
    endtask

    task automatic test_reset_mid_mem();
        instrCode = 32'h0040A283; busReady = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        n_cmp++;
        if (busRe !== 1'b1) begin
            n_bad++; $display("FAIL mid_reset pre busRe got %b want 1", busRe);
        end
        #2 reset = 1'b1;
        #1;
        cnt_model = '0;
        n_cmp++;
        if (observe() !== vec_t'('0)) begin
            n_bad++; $display("FAIL mid_reset outputs got %h want 0", observe());
        end
        n_cmp++;
        if (retiredCnt !== 32'd0) begin
            n_bad++; $display("FAIL mid_reset retiredCnt got %0d want 0", retiredCnt);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        run_instr(32'h002081B3, 0, "add_after_reset");
    endtask

    task automatic test_back_to_back();
        run_instr(32'h0040A283, 1, "b2b_lw");
        run_instr(32'h0050A223, 3, "b2b_sw");
        run_instr(32'hFFFFFFFF, 0, "b2b_illegal");
        run_instr(32'h002081B3, 0, "b2b_add");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_mem_boundary();
        test_random();
        test_reset_mid_mem();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
